regfile_port_arbiter: RTL and testbench

//   Shares the single bidirectional port of regfile_8b between two requesters:
//   req0 (loader) and req1 (local-maxima scanner).
//   Two-way round-robin arbitration; one regfile access per grant.

---
 rtl/regfile_port_arbiter_pkg.sv | 13 +
 rtl/regfile_port_arbiter_if.sv | 32 +++
 rtl/regfile_port_arbiter_rr.sv | 14 +
 rtl/regfile_port_arbiter.sv | 81 ++++++++
 tb/tb_regfile_port_arbiter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared widths and FSM encoding for the regfile port arbiter
package regfile_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_ACK    = 2'd2;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// rtl/regfile_port_arbiter_if.sv - requester-side bundle for the two regfile clients
interface regfile_port_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );

endinterface

// File: rtl/regfile_port_arbiter_rr.sv
// rtl/regfile_port_arbiter_rr.sv - two-way round-robin grant, combinational
module rr_arbiter_2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic gnt0,
  output logic gnt1
);

  // On a tie the requester that was not served last wins.
  assign gnt0 = req0 & (~req1 | rr_last);
  assign gnt1 = req1 & (~req0 | ~rr_last);

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares the single regfile port between loader and scanner
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_port_arbiter_if.slave  bus,
  output logic [AW-1:0]          rf_address,
  output logic                   rf_en_write,
  inout  wire  [DW-1:0]          rf_data
);

  state_t        r_state;
  logic          r_rr_last;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_gnt0;
  logic          w_gnt1;

  rr_arbiter_2 u_rr (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .rr_last (r_rr_last),
    .gnt0    (w_gnt0),
    .gnt1    (w_gnt1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rr_last <= 1'b1;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_owner   <= w_gnt1;
            r_rr_last <= w_gnt1;
            r_we      <= w_gnt1 ? bus.we1    : bus.we0;
            r_addr    <= w_gnt1 ? bus.addr1  : bus.addr0;
            r_wdata   <= w_gnt1 ? bus.wdata1 : bus.wdata0;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Read data is taken on the same edge that would commit a write.
          if (!r_we) begin
            if (r_owner) r_rdata1 <= rf_data;
            else         r_rdata0 <= rf_data;
          end
          r_state <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rf_en_write = (r_state == ST_ACCESS) && r_we;
  assign rf_address  = r_addr;
  assign rf_data     = rf_en_write ? r_wdata : {DW{1'bz}};

  assign bus.ack0    = (r_state == ST_ACK) && !r_owner;
  assign bus.ack1    = (r_state == ST_ACK) &&  r_owner;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed self-checking bench with a behavioural regfile on the bus
module tb_regfile_port_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] rf_address;
  logic       rf_en_write;
  wire  [7:0] rf_data;
  logic [7:0] mem [256];

  int n_checks;
  int n_errors;

  regfile_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  regfile_port_arbiter #(.AW(8), .DW(8)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .rf_address  (rf_address),
    .rf_en_write (rf_en_write),
    .rf_data     (rf_data)
  );

  // Regfile model: drives its read data whenever it is not being written.
  assign rf_data = rf_en_write ? 8'hzz : mem[rf_address];
  always @(posedge clk) if (rf_en_write) mem[rf_address] <= rf_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  // One full access from IDLE; returns three cycles later, back in IDLE.
  task automatic access(input bit who, input bit we, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_bus, input logic [7:0] exp_rself,
                        input logic [7:0] exp_rother, input string tag);
    if (who) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; end
    else     begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; end
    next_edge();
    @(negedge clk);
    check_val({tag, ".acc_en"},   16'(rf_en_write), 16'(we));
    check_val({tag, ".acc_addr"}, 16'(rf_address),  16'(a));
    check_val({tag, ".acc_bus"},  16'(rf_data),     16'(exp_bus));
    check_val({tag, ".acc_ack"},  16'({bus.ack1, bus.ack0}), 16'd0);
    next_edge();
    @(negedge clk);
    check_val({tag, ".ack"},      16'({bus.ack1, bus.ack0}), who ? 16'd2 : 16'd1);
    check_val({tag, ".ack_en"},   16'(rf_en_write), 16'd0);
    check_val({tag, ".ack_bus"},  16'(rf_data),     16'(exp_bus));
    check_val({tag, ".rself"},    16'(who ? bus.rdata1 : bus.rdata0), 16'(exp_rself));
    check_val({tag, ".rother"},   16'(who ? bus.rdata0 : bus.rdata1), 16'(exp_rother));
    next_edge();
    clear_reqs();
    @(negedge clk);
    check_val({tag, ".post_ack"}, 16'({bus.ack1, bus.ack0}), 16'd0);
  endtask

  logic [7:0] wr_addr [4] = '{8'h00, 8'h02, 8'h04, 8'h14};
  logic [7:0] wr_data [4] = '{8'h02, 8'h03, 8'h04, 8'h05};

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    rst = 1'b1;
    clear_reqs();
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;

    repeat (3) next_edge();
    @(negedge clk);
    check_val("rst.ack",    16'({bus.ack1, bus.ack0}), 16'd0);
    check_val("rst.rdata0", 16'(bus.rdata0), 16'h00);
    check_val("rst.rdata1", 16'(bus.rdata1), 16'h00);
    check_val("rst.en",     16'(rf_en_write), 16'd0);
    check_val("rst.addr",   16'(rf_address),  16'h00);
    check_val("rst.bus",    16'(rf_data),     16'h3C);
    next_edge();
    rst = 1'b0;
    @(negedge clk);

    access(1'b0, 1'b1, 8'h14, 8'h05, 8'h05, 8'h00, 8'h00, "wr14");
    access(1'b1, 1'b0, 8'h14, 8'h00, 8'h05, 8'h05, 8'h00, "rd14");

    for (int i = 0; i < 4; i++)
      access(1'b0, 1'b1, wr_addr[i], wr_data[i], wr_data[i], 8'h00, 8'h05, $sformatf("seqwr%0d", i));
    for (int i = 0; i < 4; i++)
      access(1'b1, 1'b0, wr_addr[i], 8'h00, wr_data[i], wr_data[i], 8'h00, $sformatf("seqrd%0d", i));

    // Fairness: both requesters held high from reset release.
    next_edge();
    rst = 1'b1;
    repeat (2) next_edge();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 8'hF0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h31; bus.wdata1 = 8'hF2;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("fair%0d.ack0", n), 16'(bus.ack0), 16'(n % 6 == 2));
      check_val($sformatf("fair%0d.ack1", n), 16'(bus.ack1), 16'(n % 6 == 5));
      check_val($sformatf("fair%0d.en", n),   16'(rf_en_write), 16'(n % 6 == 1));
      check_val($sformatf("fair%0d.bus", n),  16'(rf_data),
                (n % 6 >= 1 && n % 6 <= 3) ? 16'hF0 : 16'h0D);
      if (n % 6 == 5) check_val($sformatf("fair%0d.rdata1", n), 16'(bus.rdata1), 16'h0D);
    end

    // Reset during a read ACCESS by req1.
    next_edge();
    rst = 1'b1;
    clear_reqs();
    repeat (2) next_edge();
    rst = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h31;
    next_edge();
    @(negedge clk);
    check_val("midrst.acc_en",   16'(rf_en_write), 16'd0);
    check_val("midrst.acc_addr", 16'(rf_address),  16'h31);
    rst = 1'b1;
    clear_reqs();
    next_edge();
    @(negedge clk);
    check_val("midrst.ack",    16'({bus.ack1, bus.ack0}), 16'd0);
    check_val("midrst.rdata1", 16'(bus.rdata1), 16'h00);
    check_val("midrst.en",     16'(rf_en_write), 16'd0);
    check_val("midrst.bus",    16'(rf_data),     16'h02);
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst.idle_ack", 16'({bus.ack1, bus.ack0}), 16'd0);
    access(1'b0, 1'b0, 8'h14, 8'h00, 8'h05, 8'h05, 8'h00, "postrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
